bus_arbiter: RTL

Round-robin arbiter and sequencer for the shared 64-bit tri-state data bus. Up to `N` requesters drive this bus through `tristatebuf64` instances. The block decides which requester's buffer is enabled, and guarantees that at most one enable is ever high. It inserts one all-off turnaround cycle between owners so the bus never has two drivers, and it bounds each tenure with a hold limit so no requester can starve the others.

---
 rtl/bus_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter and sequencer for the shared 64-bit
// tri-state data bus. Grants at most one requester at a time. Inserts one
// all-off turnaround cycle between owners. Bounds each tenure to MAX_HOLD
// cycles.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   req      per-requester level request
//   gnt      one-hot-or-zero grant (tristatebuf64 sel per requester)
//   owner    binary index of the current grantee, 0 when idle
//   busy     high while any gnt bit is high
//   timeout  one-cycle pulse in the first turnaround after a forced release
module bus_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned IDW      = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] owner,
  output logic           busy,
  output logic           timeout
);

  // Hold counter wide enough for the largest legal MAX_HOLD (255).
  localparam int unsigned CW = 8;

  // Reject illegal parameterisations at elaboration.
  if (N < 2 || N > 8) begin : g_bad_n
    $error("bus_arbiter: N must be in 2..8");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("bus_arbiter: MAX_HOLD must be in 1..255");
  end
  if (IDW != $clog2(N)) begin : g_bad_idw
    $error("bus_arbiter: IDW must equal clog2(N)");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;
  logic [N-1:0]   gnt_nxt;
  logic [IDW-1:0] owner_nxt;
  logic           busy_nxt;
  logic           timeout_nxt;

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic           win_vld;
  logic [IDW-1:0] win_off;
  logic [IDW:0]   win_sum;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] ptr_inc;
  logic           own_req;
  logic           hold_max;
  logic           rel;

  // Rotate req so bit 0 is the requester at ptr; first set bit is the winner.
  always_comb begin
    req_dbl = {req, req};
    req_rot = N'(req_dbl >> ptr);
    win_vld = 1'b0;
    win_off = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!win_vld && req_rot[j]) begin
        win_vld = 1'b1;
        win_off = IDW'(j);
      end
    end
    win_sum = {1'b0, ptr} + {1'b0, win_off};
    if (win_sum >= (IDW+1)'(N)) begin
      win_idx = IDW'(win_sum - (IDW+1)'(N));
    end else begin
      win_idx = IDW'(win_sum);
    end
  end

  // Tenure bookkeeping: gnt is one-hot of owner, so req & gnt is req[owner].
  always_comb begin
    own_req  = |(req & gnt);
    hold_max = (cnt == CW'(MAX_HOLD));
    rel      = !own_req || hold_max;
    if (owner == IDW'(N - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = owner + IDW'(1);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      owner   <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      gnt     <= gnt_nxt;
      owner   <= owner_nxt;
      busy    <= busy_nxt;
      timeout <= timeout_nxt;
    end
  end

  // Next-state logic. TURN arbitrates exactly like IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_TURN: begin
        state_nxt = win_vld ? S_GRANT : S_IDLE;
      end
      S_GRANT: begin
        if (rel) begin
          state_nxt = S_TURN;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    gnt_nxt     = gnt;
    owner_nxt   = owner;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    case (state)
      S_IDLE, S_TURN: begin
        gnt_nxt   = '0;
        owner_nxt = '0;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
        if (win_vld) begin
          gnt_nxt   = N'(1) << win_idx;
          owner_nxt = win_idx;
          busy_nxt  = 1'b1;
          cnt_nxt   = CW'(1);
        end
      end
      S_GRANT: begin
        if (rel) begin
          // Forced release only flags timeout if the owner still wanted the bus.
          gnt_nxt     = '0;
          owner_nxt   = '0;
          busy_nxt    = 1'b0;
          timeout_nxt = own_req;
          ptr_nxt     = ptr_inc;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        gnt_nxt   = '0;
        owner_nxt = '0;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Bus safety: never two drivers, never a direct owner-to-owner handover.
  a_onehot: assert property (@(posedge clk) $onehot0(gnt));
  a_no_handover: assert property (@(posedge clk)
    ((gnt != '0) && ($past(gnt) != '0)) |-> (gnt == $past(gnt)));
  a_busy: assert property (@(posedge clk) busy == (gnt != '0));

endmodule
